// File: rtl/uart_rx_if.sv
// Serial receive bus: tick and line in, received word plus status out.
// The slave modport is the receiver side, the master modport is whoever drives the line.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] rx_data;
    logic            rx_done;
    logic            frame_err;
    logic            parity_err;
    logic            busy;

    modport master (
        output s_tick, rx,
        input  rx_data, rx_done, frame_err, parity_err, busy
    );

    modport slave (
        input  s_tick, rx,
        output rx_data, rx_done, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver driven by a 16x oversampling tick: mid-bit start validation,
// LSB-first data, optional parity, stop-bit sampling and a one-cycle done strobe.
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    uart_rx_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic par_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            rx_s_q, rx_s_d;
    logic            rx_q, rx_q_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;
    logic            busy_q, busy_d;

    // Next-state, counters, datapath and output updates.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        p_d          = p_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        sync1_d      = bus.rx;
        rx_s_d       = sync1_q;
        rx_q_d       = rx_s_q;
        case (state_q)
            IDLE: begin
                // Only a fresh 1->0 transition starts a frame, so a held break never retriggers.
                if (rx_q && !rx_s_q) begin
                    state_d = START;
                    s_d     = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == 5'd7) begin
                        s_d = 5'd0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            n_d     = 3'd0;
                            p_d     = 1'(PARITY_ODD);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == 5'd15) begin
                        s_d = 5'd0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        p_d = par_acc(p_q, rx_s_q);
                        if (n_q == 3'(DBIT - 1)) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == 5'd15) begin
                        s_d     = 5'd0;
                        p_d     = par_acc(p_q, rx_s_q);
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == 5'(SB_TICK - 1)) begin
                        s_d          = 5'd0;
                        rx_data_d    = b_q;
                        frame_err_d  = ~rx_s_q;
                        parity_err_d = (PARITY_EN != 0) && (p_q != 1'b0);
                        rx_done_d    = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 5'd0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchroniser flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_q         <= 1'b1;
            s_q          <= 5'd0;
            n_q          <= 3'd0;
            b_q          <= '0;
            p_q          <= 1'b0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            rx_s_q       <= rx_s_d;
            rx_q         <= rx_q_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            p_q          <= p_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_done    = rx_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.busy       = busy_q;
endmodule
